// File: rtl/hub75_row_scheduler.sv
// HUB75 row scheduler: fetches pixel words, slices one bit-plane per pass into shadow rows and
// hands them to the row writer. Optional statistics counters: define HUB75_SCHED_STATS_EN.
module hub75_row_scheduler #(
  parameter int unsigned ROW_BITS = 5,
  parameter int unsigned PLANES   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [7:0]            global_brt,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic [ROW_BITS+6:0]   mem_addr,
  output logic                  mem_rd,
  input  logic [47:0]           mem_data,
  input  logic                  write_can,
  input  logic                  write_next,
  input  logic                  latch,
  output logic [63:0]           buffer_r0,
  output logic [63:0]           buffer_g0,
  output logic [63:0]           buffer_b0,
  output logic [63:0]           buffer_r1,
  output logic [63:0]           buffer_g1,
  output logic [63:0]           buffer_b1,
  output logic [7:0]            buffer_brt,
  output logic [ROW_BITS-1:0]   row_addr,
  output logic                  underrun
`ifdef HUB75_SCHED_STATS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           underrun_cnt
`endif
);

  localparam int unsigned PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StReady = 2'd2;

  logic [1:0]          state, state_d;
  logic                bank;
  logic [ROW_BITS-1:0] row;
  logic [PLANE_W-1:0]  plane;
  logic [6:0]          cnt;
  logic [63:0]         sh_r0, sh_g0, sh_b0, sh_r1, sh_g1, sh_b1;
  logic [ROW_BITS-1:0] pend_row;
  logic [7:0]          pend_brt;

  logic       commit, bad_reload, last_plane, last_row, capture;
  logic [5:0] cap_col;
  logic [3:0] brt_shift;
  logic       unused_inputs;

  assign unused_inputs = write_can;

  always_comb begin
    commit     = (state == StReady) && write_next;
    bad_reload = (state != StReady) && write_next;
    last_plane = (plane == PLANE_W'(PLANES - 1));
    last_row   = &row;
    // Data for the read issued at cnt-1 is on mem_data while cnt is current.
    capture    = (state == StFetch) && (cnt != 7'd0) && en;
    cap_col    = cnt[5:0] - 6'd1;
    brt_shift  = 4'(PLANES - 1) - 4'(plane);
    mem_rd     = (state == StFetch) && !cnt[6];
    mem_addr   = {bank, row, cnt[5:0]};

    state_d = state;
    unique case (state)
      StIdle:  if (en) state_d = StFetch;
      StFetch: begin
        if (!en)                 state_d = StIdle;
        else if (cnt == 7'd64)   state_d = StReady;
      end
      StReady: begin
        if (commit)              state_d = en ? StFetch : StIdle;
        else if (!en)            state_d = StIdle;
      end
      default:                   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      bank       <= 1'b0;
      row        <= '0;
      plane      <= '0;
      cnt        <= '0;
      sh_r0      <= '0;
      sh_g0      <= '0;
      sh_b0      <= '0;
      sh_r1      <= '0;
      sh_g1      <= '0;
      sh_b1      <= '0;
      buffer_r0  <= '0;
      buffer_g0  <= '0;
      buffer_b0  <= '0;
      buffer_r1  <= '0;
      buffer_g1  <= '0;
      buffer_b1  <= '0;
      buffer_brt <= '0;
      row_addr   <= '0;
      pend_row   <= '0;
      pend_brt   <= '0;
      swap_ack   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state    <= state_d;
      swap_ack <= 1'b0;

      if (state_d == StFetch && state != StFetch) cnt <= '0;
      else if (state == StFetch)                  cnt <= cnt + 7'd1;

      if (capture) begin
        sh_r0[cap_col] <= mem_data[47:40] >> plane;
        sh_g0[cap_col] <= mem_data[39:32] >> plane;
        sh_b0[cap_col] <= mem_data[31:24] >> plane;
        sh_r1[cap_col] <= mem_data[23:16] >> plane;
        sh_g1[cap_col] <= mem_data[15:8]  >> plane;
        sh_b1[cap_col] <= mem_data[7:0]   >> plane;
      end

      if (commit) begin
        buffer_r0 <= sh_r0;
        buffer_g0 <= sh_g0;
        buffer_b0 <= sh_b0;
        buffer_r1 <= sh_r1;
        buffer_g1 <= sh_g1;
        buffer_b1 <= sh_b1;
        pend_row  <= row;
        pend_brt  <= global_brt >> brt_shift;
        if (last_plane) begin
          plane <= '0;
          row   <= row + 1'b1;
          if (last_row && swap_req) begin
            bank     <= ~bank;
            swap_ack <= 1'b1;
          end
        end else begin
          plane <= plane + 1'b1;
        end
      end

      // Disabling blanks the next latched row regardless of any commit.
      if (!en) pend_brt <= '0;

      if (latch) begin
        row_addr   <= pend_row;
        buffer_brt <= pend_brt;
      end

      if (bad_reload) underrun <= 1'b1;
    end
  end

`ifdef HUB75_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt    <= '0;
      underrun_cnt <= '0;
    end else begin
      if (commit && last_plane && last_row) frame_cnt <= frame_cnt + 16'd1;
      if (bad_reload && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hub75_row_scheduler.sv
// Scoreboard bench for hub75_row_scheduler: a bench-side frame memory and pointer model
// predict every committed row, latched brightness, swap pulse and reset value.
module tb_hub75_row_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  global_brt = 8'h00;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [47:0] mem_data = '0;
  logic        write_can = 1'b0;
  logic        write_next = 1'b0;
  logic        latch = 1'b0;
  logic [63:0] buffer_r0, buffer_g0, buffer_b0, buffer_r1, buffer_g1, buffer_b1;
  logic [7:0]  buffer_brt;
  logic [4:0]  row_addr;
  logic        underrun;
`ifdef HUB75_SCHED_STATS_EN
  logic [15:0] frame_cnt, underrun_cnt;
`endif

  hub75_row_scheduler #(.ROW_BITS(5), .PLANES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .global_brt (global_brt),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .write_can  (write_can),
    .write_next (write_next),
    .latch      (latch),
    .buffer_r0  (buffer_r0),
    .buffer_g0  (buffer_g0),
    .buffer_b0  (buffer_b0),
    .buffer_r1  (buffer_r1),
    .buffer_g1  (buffer_g1),
    .buffer_b1  (buffer_b1),
    .buffer_brt (buffer_brt),
    .row_addr   (row_addr),
    .underrun   (underrun)
`ifdef HUB75_SCHED_STATS_EN
    ,
    .frame_cnt    (frame_cnt),
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Bank 0 row 0 carries only a column ramp on r0; everything else is a mixed pattern.
  function automatic logic [47:0] pix(input logic bank, input logic [4:0] row,
                                      input logic [5:0] col);
    logic [7:0] c;
    c = {2'b00, col};
    if (!bank && row == 5'd0) return {c, 40'h0};
    return {c ^ {row, 3'b000}, ~c, c + {3'b000, row}, {bank, row, 2'b01}, c * 8'd3,
            8'h5A ^ {col, 2'b10}};
  endfunction

  always @(posedge clk) if (mem_rd) mem_data <= pix(mem_addr[11], mem_addr[10:6], mem_addr[5:0]);

  function automatic logic [63:0] exp_chan(input int ch, input logic bank, input logic [4:0] row,
                                           input int plane);
    logic [63:0] res;
    logic [47:0] d;
    logic [7:0]  b;
    for (int c = 0; c < 64; c++) begin
      d = pix(bank, row, 6'(c));
      b = d[47 - 8*ch -: 8];
      res[c] = b[plane];
    end
    return res;
  endfunction

  typedef struct {
    logic [63:0] buf_x [6];
    logic [4:0]  row;
    logic [7:0]  brt;
    logic        ack;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic       m_bank = 1'b0;
  logic [4:0] m_row = '0;
  int         m_plane = 0;
  logic [4:0] m_pend_row = '0;
  logic [7:0] m_pend_brt = '0;
  logic [4:0] m_row_addr = '0;
  logic       m_wrapped = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait out a fetch, reload, compare the committed row, optionally latch it.
  task automatic do_commit(input bit do_latch);
    exp_t e;
    exp_t g;
    logic wrap;
    repeat (68) tick();
    wrap = (m_row == 5'd31) && (m_plane == 7);
    for (int ch = 0; ch < 6; ch++) e.buf_x[ch] = exp_chan(ch, m_bank, m_row, m_plane);
    e.row = m_row;
    e.brt = global_brt >> (7 - m_plane);
    e.ack = wrap && swap_req;
    sb.push_back(e);
    write_next = 1'b1;
    tick();
    write_next = 1'b0;
    g = sb.pop_front();
    check("buf_r0", buffer_r0, g.buf_x[0]);
    check("buf_g0", buffer_g0, g.buf_x[1]);
    check("buf_b0", buffer_b0, g.buf_x[2]);
    check("buf_r1", buffer_r1, g.buf_x[3]);
    check("buf_g1", buffer_g1, g.buf_x[4]);
    check("buf_b1", buffer_b1, g.buf_x[5]);
    check("row_addr_hold", 64'(row_addr), 64'(m_row_addr));
    check("swap_ack", 64'(swap_ack), 64'(g.ack));
    m_pend_row = g.row;
    m_pend_brt = g.brt;
    m_wrapped  = wrap;
    if (m_plane == 7) begin
      m_plane = 0;
      m_row   = m_row + 5'd1;
      if (wrap && swap_req) m_bank = ~m_bank;
    end else begin
      m_plane++;
    end
    if (do_latch) begin
      latch = 1'b1;
      tick();
      latch = 1'b0;
      m_row_addr = m_pend_row;
      check("latch_brt", 64'(buffer_brt), 64'(m_pend_brt));
      check("latch_row", 64'(row_addr), 64'(m_row_addr));
      check("swap_ack_single", 64'(swap_ack), 64'd0);
    end
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_buf_r0", buffer_r0, 64'd0);
    check("rst_buf_b1", buffer_b1, 64'd0);
    check("rst_brt", 64'(buffer_brt), 64'd0);
    check("rst_row_addr", 64'(row_addr), 64'd0);
    check("rst_swap_ack", 64'(swap_ack), 64'd0);
    check("rst_mem_rd", 64'(mem_rd), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_mem_rd", 64'(mem_rd), 64'd0);

    // Underrun during the first fetch leaves buffers and pointer untouched
    global_brt = 8'hFF;
    en = 1'b1;
    repeat (10) tick();
    check("fetch_mem_rd", 64'(mem_rd), 64'd1);
    write_next = 1'b1;
    tick();
    write_next = 1'b0;
    check("underrun_set", 64'(underrun), 64'd1);
    check("underrun_buf_r0", buffer_r0, 64'd0);
    check("underrun_mem_rd", 64'(mem_rd), 64'd1);

    // Row 0 planes 0..7 (brightness ramp), then into row 1
    for (int p = 0; p < 11; p++) do_commit(1'b1);
    check("ramp_last_brt_const", 64'(global_brt >> 5), 64'h07);

    // Disable while a row is ready: blank on next latch, no reads, pointer kept
    repeat (68) tick();
    en = 1'b0;
    tick();
    m_pend_brt = 8'h00;
    check("dis_mem_rd", 64'(mem_rd), 64'd0);
    latch = 1'b1;
    tick();
    latch = 1'b0;
    m_row_addr = m_pend_row;
    check("dis_latch_brt", 64'(buffer_brt), 64'd0);
    check("dis_latch_row", 64'(row_addr), 64'(m_row_addr));
    repeat (5) tick();
    check("dis_idle_mem_rd", 64'(mem_rd), 64'd0);
    en = 1'b1;
    do_commit(1'b1);

    // Full frame with swap requested; pulse only at the frame wrap
    global_brt = 8'hB7;
    swap_req = 1'b1;
    m_wrapped = 1'b0;
    for (int n = 0; n < 300 && !m_wrapped; n++) do_commit(1'b1);
    check("frame_wrapped", 64'(m_wrapped), 64'd1);
    check("bank1_mem_rd", 64'(mem_rd), 64'd1);
    check("bank1_addr_msb", 64'(mem_addr[11]), 64'd1);
    swap_req = 1'b0;
    do_commit(1'b0);

    // Asynchronous reset in the middle of a fetch
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_buf_r0", buffer_r0, 64'd0);
    check("arst_buf_g0", buffer_g0, 64'd0);
    check("arst_buf_b1", buffer_b1, 64'd0);
    check("arst_brt", 64'(buffer_brt), 64'd0);
    check("arst_row_addr", 64'(row_addr), 64'd0);
    check("arst_mem_rd", 64'(mem_rd), 64'd0);
    check("arst_underrun", 64'(underrun), 64'd0);
    check("arst_swap_ack", 64'(swap_ack), 64'd0);
    check("arst_addr_msb", 64'(mem_addr[11]), 64'd0);
    #10;
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hub75_row_scheduler.md
Name: hub75_row_scheduler

Overview:
- Sequences the HUB75 row writer: fetches pixel words from a dual-bank frame memory and extracts one bit-plane per pass into 64-bit shadow row buffers.
- Commits the shadow buffers to the row writer on its reload handshake, then drives row address and per-plane brightness at latch time.
- Implements binary-coded modulation: for each row, planes 0..PLANES-1 in turn, then the next row.
- Sits between the frame-memory read port and the row writer.

Parameters:
ROW_BITS, 5, row address width; ROWS = 2**ROW_BITS scan rows (each row drives upper and lower half).
PLANES, 8, bit-planes per colour channel, 1..8.

Ports:
clk  in  1  system clock, also the row writer clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scheduler enable
global_brt  in  8  brightness for the MSB plane
swap_req  in  1  level; request bank swap at next frame boundary
swap_ack  out  1  one-cycle pulse when the swap is applied
mem_addr  out  7+ROW_BITS  {bank, row, col[5:0]}
mem_rd  out  1  read strobe; data returns exactly 1 cycle later
mem_data  in  48  {r0,g0,b0,r1,g1,b1}, 8 bits each, r0 at [47:40]
write_can  in  1  from row writer; informational, unused for sequencing
write_next  in  1  from row writer; reload strobe
latch  in  1  from row writer; row latch strobe
buffer_r0, buffer_g0, buffer_b0, buffer_r1, buffer_g1, buffer_b1  out  64 each  row data to the row writer
buffer_brt  out  8  OE on-time for the latched plane
row_addr  out  ROW_BITS  HUB75 A..E lines
underrun  out  1  sticky flag; cleared only by reset

Behaviour:
- Clock `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values:
  - All buffer_* = 0, buffer_brt = 0 (panel dark), row_addr = 0.
  - swap_ack = 0, mem_rd = 0, underrun = 0, bank = 0.
  - Fetch pointer (row, plane) = (0, 0). State = IDLE.
  - A reset asserted mid-operation aborts everything immediately.
- States:
  - IDLE: wait for en = 1, then go to FETCH.
  - FETCH: issue mem_rd for col 0..63 on consecutive cycles, mem_addr = {bank, row, col}.
    - Capture on the cycle after each read: shadow_x[col] = mem_data channel x bit [plane].
    - 65 cycles total. The cycle that captures col 63 moves to READY.
  - READY: hold the shadow buffers and wait for write_next.
- Commit (write_next while in READY):
  - Copy all six shadows to buffer_* in the same edge.
  - Record pend_row = row and pend_brt = global_brt >> (PLANES-1-plane).
  - Advance the pointer: plane+1; on plane wrap, row+1; on row wrap, frame boundary.
  - Go to FETCH (or IDLE if en = 0).
- Frame boundary: if swap_req = 1, toggle bank and pulse swap_ack in the same cycle the pointer wraps to (0, 0).
- Latch: on latch = 1, row_addr <= pend_row and buffer_brt <= pend_brt, both registered. buffer_brt is therefore never updated by write_next.
- Underrun:
  - write_next while not in READY (including the cycle col 63 is captured) sets underrun.
  - buffer_* are left unchanged (the row repeats), the pointer does not advance, and fetch continues.
- en deassertion:
  - Abort any fetch and go to IDLE; mem_rd = 0 in the next cycle.
  - pend_brt <= 0, so the next latch blanks the panel. row_addr is unchanged.
  - The pointer is kept, and fetch restarts at it when en rises.
- Width rule: global_brt >> shift is truncated with no rounding; plane 0 of an 8-plane build gets global_brt[7].
- mem_rd is never asserted outside FETCH.

Optional Feature:
HUB75_SCHED_STATS_EN:
- Defined: adds outputs frame_cnt (16, increments at every frame boundary, wraps) and underrun_cnt (16, increments per underrun event, saturates at 0xFFFF). Both reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then en = 1, memory col c = 48'h0 except r0 byte = c[7:0]; plane 0 commit -> buffer_r0 bit c = c[0] (64'hAAAA_AAAA_AAAA_AAAA), all other buffers 0.
- global_brt = 8'hFF, PLANES = 8: latches after commits of planes 0..7 -> buffer_brt sequence 01, 03, 07, 0F, 1F, 3F, 7F, FF; row_addr changes only on the latch cycle.
- write_next at the 10th FETCH cycle -> underrun = 1, buffer_* unchanged, next commit still carries (row 0, plane 0).
- swap_req = 1 held through a full frame -> swap_ack single pulse at the (ROWS-1, PLANES-1) commit; subsequent mem_addr MSB = 1.
- en dropped in READY, then latch -> buffer_brt = 0, mem_rd = 0; en raised -> fetch resumes at the saved (row, plane).
- rst_n low mid-FETCH -> all outputs return to reset values asynchronously, without waiting for a clk edge.
